// File: rtl/data_mem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package data_mem_arb_pkg;

    // Access size encodings seen on both the requester side and the memory side.
    localparam logic [1:0] SIZE_BYTE    = 2'b00;
    localparam logic [1:0] SIZE_HALF    = 2'b01;
    localparam logic [1:0] SIZE_WORD    = 2'b10;
    localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

    // Identifies which requester owns a command or response.
    typedef enum logic {
        PORT_0 = 1'b0,
        PORT_1 = 1'b1
    } port_id_t;

    // Width-independent part of a registered command. The address and store data
    // are added by the top module, where ADDR_W and DATA_W are known.
    typedef struct packed {
        logic     we;
        logic [1:0] size;
        logic     is_unsigned;
        logic     err;
        port_id_t port;
    } cmd_ctrl_t;

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Requester-side bus of the data-memory arbiter: one instance per port.
// The requester uses the master modport, the arbiter the slave modport.
interface data_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [1:0]        size;
    logic              is_unsigned;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;
    logic              err;

    modport master (
        output req, we, addr, wdata, size, is_unsigned,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, we, addr, wdata, size, is_unsigned,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/data_mem_arbiter_mem_align_check.sv
// Flags accesses whose size is illegal or whose address is not naturally aligned.
module mem_align_check
    import data_mem_arb_pkg::*;
(
    input  logic [1:0] size,
    input  logic [1:0] addr_lo,
    output logic       err
);

    // Half-words need an even address, words a multiple of four; size 11 never exists.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and infers a latch.
        err = 1'b0;
        case (size)
            SIZE_BYTE: err = 1'b0;
            SIZE_HALF: err = addr_lo[0];
            SIZE_WORD: err = |addr_lo;
            default:   err = 1'b1;
        endcase
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter in front of a single data-memory port.
// Port 0 is the CPU load/store stage, port 1 a loader or DMA engine.
// Accepted requests pass through a command register that drives the memory and
// a response register that returns the read data one cycle later.
// Optional macro DATA_MEM_ARB_ROUND_ROBIN_EN: when defined, ties alternate using
// last_grant; when undefined, port 0 always wins ties.
module data_mem_arbiter
    import data_mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    data_mem_arbiter_if.slave   p0,
    data_mem_arbiter_if.slave   p1,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W-1:0]   mem_write_data,
    output logic [1:0]          mem_data_size,
    output logic                mem_extension_type,
    output logic                mem_write_enable,
    input  logic [DATA_W-1:0]   mem_read_data,
    output logic                busy
);

    typedef struct packed {
        cmd_ctrl_t         ctrl;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

    logic gnt0;
    logic gnt1;
    logic accept;
    logic sel_err;
    cmd_t next_cmd;

    logic cmd_valid;
    cmd_t cmd;

    logic              rsp_valid;
    port_id_t          rsp_port;
    logic              rsp_err;
    logic [DATA_W-1:0] rsp_rdata;

`ifdef DATA_MEM_ARB_ROUND_ROBIN_EN
    port_id_t last_grant;

    // Remember the most recent winner; starting at port 1 hands the first tie to port 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            last_grant <= PORT_1;
        end else if (accept) begin
            last_grant <= gnt1 ? PORT_1 : PORT_0;
        end
    end

    // On a tie, grant the port that did not win last time.
    always_comb begin
        gnt0 = p0.req & (~p1.req | (last_grant == PORT_1));
        gnt1 = p1.req & (~p0.req | (last_grant == PORT_0));
    end
`else
    // Fixed priority: port 0 wins every tie, so port 1 may starve.
    always_comb begin
        gnt0 = p0.req;
        gnt1 = p1.req & ~p0.req;
    end
`endif

    assign p0.gnt = gnt0;
    assign p1.gnt = gnt1;
    assign accept = gnt0 | gnt1;

    // Select the winning request's fields into the next command.
    always_comb begin
        next_cmd = '0;
        if (gnt1) begin
            next_cmd.ctrl.we          = p1.we;
            next_cmd.ctrl.size        = p1.size;
            next_cmd.ctrl.is_unsigned = p1.is_unsigned;
            next_cmd.ctrl.port        = PORT_1;
            next_cmd.addr             = p1.addr;
            next_cmd.wdata            = p1.wdata;
        end else begin
            next_cmd.ctrl.we          = p0.we;
            next_cmd.ctrl.size        = p0.size;
            next_cmd.ctrl.is_unsigned = p0.is_unsigned;
            next_cmd.ctrl.port        = PORT_0;
            next_cmd.addr             = p0.addr;
            next_cmd.wdata            = p0.wdata;
        end
        next_cmd.ctrl.err = sel_err;
    end

    mem_align_check u_align (
        .size    (next_cmd.ctrl.size),
        .addr_lo (next_cmd.addr[1:0]),
        .err     (sel_err)
    );

    // Command stage: the payload only loads on an accept, so the memory inputs
    // hold their last values while the stage is idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the payload is reset as well so every memory-side output reads 0 out of reset.
            cmd_valid <= 1'b0;
            cmd       <= '0;
        end else begin
            cmd_valid <= accept;
            if (accept) begin
                cmd <= next_cmd;
            end
        end
    end

    assign mem_address        = cmd.addr;
    assign mem_write_data     = cmd.wdata;
    assign mem_data_size      = cmd.ctrl.size;
    assign mem_extension_type = cmd.ctrl.is_unsigned;
    // Erroneous stores never write; reset clears cmd_valid and so drops this at once.
    assign mem_write_enable   = cmd_valid & cmd.ctrl.we & ~cmd.ctrl.err;

    // Response stage: capture load data at the end of the command cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_port  <= PORT_0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= cmd_valid;
            if (cmd_valid) begin
                rsp_port  <= cmd.ctrl.port;
                rsp_err   <= cmd.ctrl.err;
                rsp_rdata <= (~cmd.ctrl.we & ~cmd.ctrl.err) ? mem_read_data : '0;
            end
        end
    end

    // Route the single response to its originating port; the other port sees zeros.
    always_comb begin
        p0.rvalid = rsp_valid & (rsp_port == PORT_0);
        p1.rvalid = rsp_valid & (rsp_port == PORT_1);
        p0.err    = p0.rvalid & rsp_err;
        p1.err    = p1.rvalid & rsp_err;
        p0.rdata  = p0.rvalid ? rsp_rdata : '0;
        p1.rdata  = p1.rvalid ? rsp_rdata : '0;
    end

    assign busy = cmd_valid | rsp_valid;

endmodule
